mux_decode_pipe: RTL and testbench

//   Parametrised successor to the 2-bit A/B select + one-hot decode + pair-XOR block.
//   - Selects one W-bit code from NCH input channels and decodes it to a 2**W one-hot vector.
//   - Produces pair-XOR flags and a code-changed flag.
//   - Moves data through a 2-stage valid/ready pipeline with back-pressure.
//   - Sits between code sources and the status/display logic in the lab datapath.

---
 rtl/mux_decode_pkg.sv | 16 +
 rtl/mux_decode_pipe_if.sv | 30 +++
 rtl/code_onehot_dec.sv | 19 +
 rtl/mux_decode_pipe.sv | 114 +++++++++++
 tb/tb_mux_decode_pipe.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_decode_pkg.sv
// Shared defaults and width helpers for the mux/decode pipeline.
package mux_decode_pkg;

  localparam int DEF_W     = 2;
  localparam int DEF_NCH   = 2;
  localparam int DEF_CNT_W = 8;

  function automatic int onehot_w(input int w);
    return 1 << w;
  endfunction

  function automatic int pair_w(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/mux_decode_pipe_if.sv
// Input-word / output-word handshake bundle for mux_decode_pipe.
interface mux_decode_pipe_if #(
  parameter int W   = mux_decode_pkg::DEF_W,
  parameter int NCH = mux_decode_pkg::DEF_NCH
);
  localparam int SELW = $clog2(NCH);
  localparam int OHW  = mux_decode_pkg::onehot_w(W);
  localparam int PW   = mux_decode_pkg::pair_w(W);

  logic               in_valid;
  logic               in_ready;
  logic [NCH*W-1:0]   in_code;
  logic [SELW-1:0]    in_sel;
  logic               out_valid;
  logic               out_ready;
  logic [OHW-1:0]     onehot;
  logic [PW-1:0]      pair_xor;
  logic               code_changed;
  logic               sel_err;

  modport master (
    output in_valid, in_code, in_sel, out_ready,
    input  in_ready, out_valid, onehot, pair_xor, code_changed, sel_err
  );

  modport slave (
    input  in_valid, in_code, in_sel, out_ready,
    output in_ready, out_valid, onehot, pair_xor, code_changed, sel_err
  );
endinterface

// File: rtl/code_onehot_dec.sv
// Combinational W -> 2**W one-hot decoder with adjacent-pair XOR flags.
module code_onehot_dec
  import mux_decode_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0]           code,
  output logic [onehot_w(W)-1:0] onehot,
  output logic [pair_w(W)-1:0]   pair_xor
);
  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

  for (genvar k = 0; k < pair_w(W); k++) begin : g_pair
    assign pair_xor[k] = onehot[2*k] ^ onehot[2*k+1];
  end
endmodule

// File: rtl/mux_decode_pipe.sv
// Channel select + one-hot decode behind a 2-stage valid/ready pipeline.
// Optional per-code saturating hit counters when HIT_COUNT_EN is defined.
module mux_decode_pipe
  import mux_decode_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clock,
  input  logic             Reset_n,
  mux_decode_pipe_if.slave bus,
  input  logic             clr_cnt,
  input  logic [W-1:0]     rd_idx,
  output logic [CNT_W-1:0] rd_cnt
);
  localparam int OHW    = onehot_w(W);
  localparam int PW     = pair_w(W);
  localparam int SELW   = $clog2(NCH);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [W-1:0] code;
    logic         err;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  logic            s1_rdy, s2_rdy, in_fire, s2_load;
  s1_t             s1_in, s1_q;
  logic [OHW-1:0]  oh_d, oh_q;
  logic [PW-1:0]   px_d, px_q;
  logic            cc_q, err_q, first_flag;
  logic [W-1:0]    prev_code;

  assign s2_rdy       = !vld_pipe[2] || bus.out_ready;
  assign s1_rdy       = !vld_pipe[1] || s2_rdy;
  assign bus.in_ready = s1_rdy;
  assign in_fire      = bus.in_valid && s1_rdy;
  assign s2_load      = vld_pipe[1] && s2_rdy;

  // Out-of-range selects fall back to channel 0 and flag the word.
  always_comb begin
    s1_in.code = bus.in_code[W-1:0];
    s1_in.err  = (32'(bus.in_sel) >= NCH);
    for (int c = 1; c < NCH; c++)
      if (bus.in_sel == SELW'(c)) s1_in.code = bus.in_code[c*W +: W];
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_fire || (vld_pipe[1] && !s2_load);
      vld_pipe[2] <= s2_load || (vld_pipe[2] && !bus.out_ready);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)     s1_q <= '0;
    else if (in_fire) s1_q <= s1_in;
  end

  code_onehot_dec #(.W(W)) u_dec (
    .code     (s1_q.code),
    .onehot   (oh_d),
    .pair_xor (px_d)
  );

  // prev_code doubles as the code of the word currently held in S2.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      oh_q       <= '0;
      px_q       <= '0;
      cc_q       <= 1'b0;
      err_q      <= 1'b0;
      prev_code  <= '0;
      first_flag <= 1'b1;
    end else if (s2_load) begin
      oh_q       <= oh_d;
      px_q       <= px_d;
      cc_q       <= first_flag || (s1_q.code != prev_code);
      err_q      <= s1_q.err;
      prev_code  <= s1_q.code;
      first_flag <= 1'b0;
    end
  end

  assign bus.out_valid    = vld_pipe[2];
  assign bus.onehot       = oh_q;
  assign bus.pair_xor     = px_q;
  assign bus.code_changed = cc_q;
  assign bus.sel_err      = err_q;

`ifdef HIT_COUNT_EN
  logic [OHW-1:0][CNT_W-1:0] cnt;
  logic                      out_fire;

  assign out_fire = vld_pipe[2] && bus.out_ready;

  // Clear beats a same-cycle increment.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)     cnt <= '0;
    else if (clr_cnt) cnt <= '0;
    else if (out_fire && (cnt[prev_code] != {CNT_W{1'b1}}))
      cnt[prev_code] <= cnt[prev_code] + 1'b1;
  end

  assign rd_cnt = cnt[rd_idx];
`else
  logic unused_cnt_in;
  assign unused_cnt_in = ^{clr_cnt, rd_idx};
  assign rd_cnt        = '0;
`endif
endmodule

// File: tb/tb_mux_decode_pipe.sv
// Directed bench for mux_decode_pipe (W=2, NCH=3, CNT_W=2); scoreboarded outputs.
module tb_mux_decode_pipe;
  localparam int W     = 2;
  localparam int NCH   = 3;
  localparam int CNT_W = 2;

  logic             Clock = 1'b0;
  logic             Reset_n = 1'b0;
  logic             clr_cnt;
  logic [W-1:0]     rd_idx;
  logic [CNT_W-1:0] rd_cnt;

  always #5 Clock = ~Clock;

  mux_decode_pipe_if #(.W(W), .NCH(NCH)) bus ();

  mux_decode_pipe #(.W(W), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus.slave),
    .clr_cnt (clr_cnt),
    .rd_idx  (rd_idx),
    .rd_cnt  (rd_cnt)
  );

  typedef struct {
    logic [5:0] code;
    logic [1:0] sel;
    logic [3:0] oh;
    logic [1:0] px;
    logic       cc;
    logic       err;
  } vec_t;

  typedef struct {
    logic [3:0] oh;
    logic [1:0] px;
    logic       cc;
    logic       err;
  } exp_t;

  exp_t expq[$];
  int   dly_cyc[$];
  exp_t mon_e;
  int   cyc = 0;
  int   acc_cyc, acc0;
  int   checks = 0;
  int   failures = 0;
  vec_t tv[7];

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (Reset_n && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got onehot %b expected no word", bus.onehot);
      end else begin
        mon_e = expq.pop_front();
        chk("out_onehot", 32'(bus.onehot), 32'(mon_e.oh));
        chk("out_pair_xor", 32'(bus.pair_xor), 32'(mon_e.px));
        chk("out_code_changed", 32'(bus.code_changed), 32'(mon_e.cc));
        chk("out_sel_err", 32'(bus.sel_err), 32'(mon_e.err));
        dly_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [5:0] code, input logic [1:0] sel, input exp_t e);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    bus.in_sel   = sel;
    for (int n = 0; n < 50; n++) begin
      @(negedge Clock);
      if (bus.in_ready) begin
        acc_cyc = cyc;
        @(posedge Clock);
        expq.push_back(e);
        #1;
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (expq.size() == 0) break;
      tick();
    end
    chk("drain_empty", expq.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    tv[0] = '{6'b00_11_01, 2'd1, 4'b1000, 2'b10, 1'b1, 1'b0};
    tv[1] = '{6'b00_11_01, 2'd1, 4'b1000, 2'b10, 1'b0, 1'b0};
    tv[2] = '{6'b00_11_01, 2'd0, 4'b0010, 2'b01, 1'b1, 1'b0};
    tv[3] = '{6'b10_11_01, 2'd2, 4'b0100, 2'b10, 1'b1, 1'b0};
    tv[4] = '{6'b10_11_10, 2'd3, 4'b0100, 2'b10, 1'b0, 1'b1};
    tv[5] = '{6'b00_11_10, 2'd2, 4'b0001, 2'b01, 1'b1, 1'b0};
    tv[6] = '{6'b00_11_11, 2'd3, 4'b1000, 2'b10, 1'b1, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b1;
    clr_cnt       = 1'b0;
    rd_idx        = '0;

    // reset state
    repeat (2) @(negedge Clock);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_onehot", 32'(bus.onehot), 0);
    chk("rst_pair_xor", 32'(bus.pair_xor), 0);
    chk("rst_code_changed", 32'(bus.code_changed), 0);
    chk("rst_sel_err", 32'(bus.sel_err), 0);
    tick();
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    tick();

    // streamed table vectors at full rate
    dly_cyc.delete();
    for (int i = 0; i < 7; i++) begin
      send(tv[i].code, tv[i].sel, '{tv[i].oh, tv[i].px, tv[i].cc, tv[i].err});
      if (i == 0) acc0 = acc_cyc;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("stream_count", dly_cyc.size(), 7);
    if (dly_cyc.size() == 7) begin
      chk("latency", dly_cyc[0] - acc0, 2);
      for (int i = 1; i < 7; i++) chk("throughput", dly_cyc[i] - dly_cyc[i-1], 1);
    end

    // back-pressure: two words fill the pipe, then everything holds
    bus.out_ready = 1'b0;
    send(6'b00_00_00, 2'd0, '{4'b0001, 2'b01, 1'b1, 1'b0});
    send(6'b00_01_00, 2'd1, '{4'b0010, 2'b01, 1'b1, 1'b0});
    bus.in_valid = 1'b1;
    bus.in_code  = 6'b10_01_00;
    bus.in_sel   = 2'd2;
    for (int n = 0; n < 5; n++) begin
      @(negedge Clock);
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_out_valid", 32'(bus.out_valid), 1);
      chk("stall_onehot", 32'(bus.onehot), 32'(4'b0001));
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge Clock);
    chk("simul_in_ready", 32'(bus.in_ready), 1);
    chk("simul_out_valid", 32'(bus.out_valid), 1);
    expq.push_back('{4'b0100, 2'b10, 1'b1, 1'b0});
    tick();
    send(6'b10_01_11, 2'd0, '{4'b1000, 2'b10, 1'b1, 1'b0});
    bus.in_valid = 1'b0;
    drain();

    // async reset with both stages full
    bus.out_ready = 1'b0;
    send(6'b00_10_00, 2'd1, '{4'b0100, 2'b10, 1'b1, 1'b0});
    send(6'b01_10_00, 2'd2, '{4'b0010, 2'b01, 1'b1, 1'b0});
    bus.in_valid = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_onehot", 32'(bus.onehot), 0);
    expq.delete();
    tick();
    Reset_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("midrst_no_output", 32'(bus.out_valid), 0);
    send(6'b00_00_00, 2'd0, '{4'b0001, 2'b01, 1'b1, 1'b0});
    bus.in_valid = 1'b0;
    drain();

`ifdef HIT_COUNT_EN
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    rd_idx  = 2'd0;
    @(negedge Clock);
    chk("cnt_after_clr", 32'(rd_cnt), 0);
    tick();
    for (int i = 0; i < 5; i++) send(6'b00_00_00, 2'd0, '{4'b0001, 2'b01, 1'b0, 1'b0});
    bus.in_valid = 1'b0;
    drain();
    rd_idx = 2'd0;
    @(negedge Clock);
    chk("cnt_saturate", 32'(rd_cnt), 3);
    tick();
    rd_idx = 2'd1;
    @(negedge Clock);
    chk("cnt_other_idx", 32'(rd_cnt), 0);
    tick();
    bus.out_ready = 1'b0;
    send(6'b00_00_00, 2'd0, '{4'b0001, 2'b01, 1'b0, 1'b0});
    bus.in_valid = 1'b0;
    tick();
    clr_cnt       = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    clr_cnt = 1'b0;
    rd_idx  = 2'd0;
    @(negedge Clock);
    chk("cnt_clr_wins", 32'(rd_cnt), 0);
    tick();
    send(6'b10_00_00, 2'd2, '{4'b0100, 2'b10, 1'b1, 1'b0});
    bus.in_valid = 1'b0;
    drain();
    rd_idx = 2'd2;
    @(negedge Clock);
    chk("cnt_count_after_clr", 32'(rd_cnt), 1);
`else
    clr_cnt = 1'b1;
    rd_idx  = 2'd0;
    @(negedge Clock);
    chk("nocnt_rd0", 32'(rd_cnt), 0);
    tick();
    clr_cnt = 1'b0;
    rd_idx  = 2'd3;
    @(negedge Clock);
    chk("nocnt_rd3", 32'(rd_cnt), 0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
